apb_regfile_completer: RTL and testbench

APB_REGFILE_COMPLETER -- requirements
Module: apb_regfile_completer

---
 rtl/apb_regfile_completer.sv | 110 +++++++++++
 tb/tb_apb_regfile_completer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_completer.sv
// APB completer: NUM_REGS-entry register file, top entry is a read-only transfer counter.
// Define APB_PSLVERR_EN to report out-of-range or read-only writes on PSLVERR.
module apb_regfile_completer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int          IW   = $clog2(NUM_REGS);
  localparam logic [5:0]  LAST = 6'(NUM_REGS - 1);
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [5:0]    idx;
  logic [IW-1:0] ridx;
  logic          bad_idx;
  logic          ready;
  logic          wr_en;

  assign idx     = PADDR[5:0];
  assign ridx    = idx[IW-1:0];
  assign bad_idx = idx > LAST;

  if (ADDR_WIDTH > 6) begin : g_unused
    logic unused_addr;
    assign unused_addr = ^PADDR[ADDR_WIDTH-1:6];
  end

  // SETUP holds during the first access cycle; cnt counts wait cycles served
  assign ready = (state != IDLE) && PSEL && PENABLE && (cnt == WS);
  assign wr_en = ready && PWRITE && (idx < LAST);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (PSEL && !PENABLE) state_nxt = SETUP;
      end
      SETUP, ACCESS: begin
        if (!PSEL)         state_nxt = IDLE;
        else if (!PENABLE) state_nxt = SETUP;
        else if (ready)    state_nxt = IDLE;
        else               state_nxt = ACCESS;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    PREADY = ready;
    PRDATA = '0;
    if (ready && !PWRITE && !bad_idx) PRDATA = regs[ridx];
`ifdef APB_PSLVERR_EN
    PSLVERR = ready && (bad_idx || (PWRITE && (idx == LAST)));
`else
    PSLVERR = 1'b0;
`endif
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cnt <= '0;
    end else if (state_nxt == ACCESS) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= '0;
    end
  end

  // Top entry doubles as the completed-transfer counter
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (ready) regs[NUM_REGS-1] <= regs[NUM_REGS-1] + DATA_WIDTH'(1);
      if (wr_en) regs[ridx] <= PWDATA;
    end
  end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Scoreboard bench for apb_regfile_completer; APB_PSLVERR_EN selects error expectations.
`timescale 1ns/1ps
module tb_apb_regfile_completer;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int NR = 16;
  localparam int WS = 2;
`ifdef APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          PCLK    = 1'b0;
  logic          PRESETN = 1'b0;
  logic          PSEL    = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE  = 1'b0;
  logic [AW-1:0] PADDR   = '0;
  logic [DW-1:0] PWDATA  = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_regfile_completer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .WAIT_STATES(WS)
  ) dut (
    .PCLK   (PCLK),
    .PRESETN(PRESETN),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] m_regs [NR];
  logic [DW-1:0] m_cnt;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_cnt = '0;
  endtask

  // Reference: low NR-1 words are storage, word NR-1 is a transfer count
  task automatic model(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output exp_t e);
    int i;
    i      = int'(a[5:0]);
    e.addr = a;
    e.data = '0;
    e.err  = 1'b0;
    if (i >= NR) e.err = ERR_EN;
    else if (wr) begin
      if (i == NR - 1) e.err = ERR_EN;
      else m_regs[i] = d;
    end else begin
      e.data = (i == NR - 1) ? m_cnt : m_regs[i];
    end
    m_cnt = m_cnt + 1'b1;
  endtask

  always @(negedge PCLK) begin
    exp_t e;
    if (PRESETN && PREADY) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pready: got PREADY=1 required 0");
      end else begin
        e = q.pop_front();
        chk($sformatf("prdata@%0h", e.addr), 32'(PRDATA), 32'(e.data));
        chk($sformatf("pslverr@%0h", e.addr), 32'(PSLVERR), 32'(e.err));
      end
    end
  end

  task automatic drive(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit garb);
    if (garb) begin
      PWRITE = 1'($urandom);
      PADDR  = AW'($urandom);
      PWDATA = DW'($urandom);
    end else begin
      PWRITE = wr;
      PADDR  = a;
      PWDATA = d;
    end
  endtask

  // Entered and left at posedge+1; abort_at = access cycles before PSEL drops
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int abort_at, input bit scr);
    exp_t e;
    int   cyc;
    bit   got;
    if (abort_at > WS) begin
      model(wr, a, d, e);
      q.push_back(e);
    end
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    drive(wr, a, d, scr);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 0;
    forever begin
      if (cyc == abort_at) begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        @(posedge PCLK); #1;
        break;
      end
      drive(wr, a, d, scr && (cyc < WS));
      @(negedge PCLK);
      got = PREADY;
      @(posedge PCLK); #1;
      if (got) begin
        chk("ready_cycle", 32'(cyc), 32'(WS));
        break;
      end
      cyc++;
      if (cyc > WS + 3) begin
        chk("ready_timeout", 32'(cyc), 32'(WS));
        break;
      end
    end
    PSEL    = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    m_clear();
    repeat (3) @(posedge PCLK);
    #1;
    PSEL    = 1'b1;
    PENABLE = 1'b1;
    #2;
    chk("reset_pready", 32'(PREADY), 32'd0);
    chk("reset_prdata", 32'(PRDATA), 32'd0);
    chk("reset_pslverr", 32'(PSLVERR), 32'd0);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    idle(1);

    xfer(1'b1, 10'd3, 16'hA5A5, 99, 1'b0);
    idle(1);
    xfer(1'b0, 10'd3, 16'h0, 99, 1'b0);
    xfer(1'b1, 10'd20, 16'hDEAD, 99, 1'b0);
    xfer(1'b1, 10'd5, 16'h1111, 99, 1'b0);
    xfer(1'b0, 10'd5, 16'h0, 99, 1'b0);
    xfer(1'b0, 10'd15, 16'h0, 99, 1'b0);
    xfer(1'b0, 10'd15, 16'h0, 99, 1'b0);
    xfer(1'b1, 10'd15, 16'hBEEF, 99, 1'b0);
    xfer(1'b0, 10'd40, 16'h0, 99, 1'b0);

    xfer(1'b1, 10'd2, 16'h1234, 1, 1'b0);
    idle(1);
    xfer(1'b0, 10'd2, 16'h0, 99, 1'b0);

    PSEL    = 1'b1;
    PENABLE = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 10'd1;
    PWDATA  = 16'hFFFF;
    idle(3);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    idle(1);
    xfer(1'b0, 10'd1, 16'h0, 99, 1'b0);

    for (int k = 0; k < 300; k++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) a[5:0] = 6'($urandom_range(0, NR - 1));
      xfer(1'($urandom), a, DW'($urandom),
           ($urandom_range(0, 7) == 0) ? $urandom_range(0, WS) : 99,
           1'($urandom));
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 2));
    end

    xfer(1'b1, 10'd3, 16'h5A5A, 99, 1'b0);
    idle(1);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 10'd3;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    idle(WS);
    chk("pre_reset_pready", 32'(PREADY), 32'd1);
    chk("pre_reset_prdata", 32'(PRDATA), 32'(m_regs[3]));
    #1;
    PRESETN = 1'b0;
    #1;
    chk("mid_reset_pready", 32'(PREADY), 32'd0);
    chk("mid_reset_prdata", 32'(PRDATA), 32'd0);
    m_clear();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    idle(1);
    for (int i = 0; i < NR; i++) xfer(1'b0, AW'(i), 16'h0, 99, 1'b0);

    idle(3);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
